// File: rtl/overlay_ctrl_if.sv
// rtl/overlay_ctrl_if.sv - host, stream and overlay-side signal bundle for overlay_ctrl
//
// Groups every non-clock/reset signal of overlay_ctrl.
//   slave  : the sequencer's view (config/start/stream/result inputs, overlay drive outputs)
//   master : the driving side's view (host + overlay model)
// Config  : cfg_we, cfg_addr, cfg_inst, start, inst_cnt, compute_cycles
// Streams : s_data_v/s_data/s_data_rdy (operands in), m_data_v/m_data/m_data_last (results out)
// Overlay : inst_in_v/inst_in, din_overlay_v/din_overlay, load, dout_overlay_v/dout_overlay
// Status  : busy, done, err
interface overlay_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int INST_WIDTH = 64,
    parameter int INST_DEPTH = 16
);
    localparam int AW = $clog2(INST_DEPTH);
    localparam int WW = 2 * DATA_WIDTH;

    logic                  cfg_we;
    logic [AW-1:0]         cfg_addr;
    logic [INST_WIDTH-1:0] cfg_inst;
    logic                  start;
    logic [AW:0]           inst_cnt;
    logic [15:0]           compute_cycles;
    logic                  s_data_v;
    logic [WW-1:0]         s_data;
    logic                  s_data_rdy;
    logic                  inst_in_v;
    logic [INST_WIDTH-1:0] inst_in;
    logic                  din_overlay_v;
    logic [WW-1:0]         din_overlay;
    logic                  load;
    logic                  dout_overlay_v;
    logic [WW-1:0]         dout_overlay;
    logic                  m_data_v;
    logic [WW-1:0]         m_data;
    logic                  m_data_last;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport slave (
        input  cfg_we, cfg_addr, cfg_inst, start, inst_cnt, compute_cycles,
        input  s_data_v, s_data, dout_overlay_v, dout_overlay,
        output s_data_rdy, inst_in_v, inst_in, din_overlay_v, din_overlay, load,
        output m_data_v, m_data, m_data_last, busy, done, err
    );

    modport master (
        output cfg_we, cfg_addr, cfg_inst, start, inst_cnt, compute_cycles,
        output s_data_v, s_data, dout_overlay_v, dout_overlay,
        input  s_data_rdy, inst_in_v, inst_in, din_overlay_v, din_overlay, load,
        input  m_data_v, m_data, m_data_last, busy, done, err
    );
endinterface

// File: rtl/overlay_ctrl.sv
// rtl/overlay_ctrl.sv - job sequencer for the PE-array overlay
//
// Runs one job per start: broadcast store[0..inst_cnt-1], stream PE_NUM operand
// words into the overlay, wait compute_cycles, pulse load, collect PE_NUM results.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-low reset (instruction store is not reset)
//   bus  : overlay_ctrl_if.slave, see the interface file for the signal list
// All outputs are registered and reset to 0.
module overlay_ctrl #(
    parameter int PE_NUM        = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int INST_WIDTH    = 64,
    parameter int INST_DEPTH    = 16,
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    overlay_ctrl_if.slave  bus
);
    localparam int AW = $clog2(INST_DEPTH);
    localparam int WW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(PE_NUM) + 1;
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [CW-1:0] LAST_WORD = CW'(PE_NUM - 1);
    localparam logic [TW-1:0] IDLE_MAX  = TW'(DRAIN_TIMEOUT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INST  = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_LOAD  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]            state;
    logic [AW:0]           inst_cnt_q;
    logic [AW:0]           inst_idx;
    logic [15:0]           compute_q;
    logic [15:0]           wait_cnt;
    logic [CW-1:0]         word_cnt;
    logic [TW-1:0]         idle_cnt;

    logic                  rdy_q;
    logic                  inst_v_q;
    logic [INST_WIDTH-1:0] inst_q;
    logic                  din_v_q;
    logic [WW-1:0]         din_q;
    logic                  load_q;
    logic                  m_v_q;
    logic [WW-1:0]         m_q;
    logic                  m_last_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic [INST_WIDTH-1:0] store [INST_DEPTH];
    logic                  store_we;
    logic [INST_WIDTH-1:0] first_inst;

    assign store_we = bus.cfg_we && (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (store_we) begin
            store[bus.cfg_addr] <= bus.cfg_inst;
        end
    end

    // Entry 0 is read on the start edge itself, so a write to address 0 in
    // that same cycle must be forwarded. Later entries are read at least one
    // edge after any IDLE write, so they come straight from the array.
    always_comb begin
        first_inst = store[0];
        if (store_we && (bus.cfg_addr == '0)) begin
            first_inst = bus.cfg_inst;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            inst_cnt_q <= '0;
            inst_idx   <= '0;
            compute_q  <= '0;
            wait_cnt   <= '0;
            word_cnt   <= '0;
            idle_cnt   <= '0;
            rdy_q      <= 1'b0;
            inst_v_q   <= 1'b0;
            inst_q     <= '0;
            din_v_q    <= 1'b0;
            din_q      <= '0;
            load_q     <= 1'b0;
            m_v_q      <= 1'b0;
            m_q        <= '0;
            m_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // single-cycle strobes default low
            inst_v_q <= 1'b0;
            din_v_q  <= 1'b0;
            load_q   <= 1'b0;
            m_v_q    <= 1'b0;
            m_last_q <= 1'b0;
            done_q   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        inst_cnt_q <= bus.inst_cnt;
                        compute_q  <= bus.compute_cycles;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        word_cnt   <= '0;
                        wait_cnt   <= '0;
                        idle_cnt   <= '0;
                        if (bus.inst_cnt != '0) begin
                            state    <= S_INST;
                            inst_v_q <= 1'b1;
                            inst_q   <= first_inst;
                            inst_idx <= (AW+1)'(1);
                        end else begin
                            state <= S_FEED;
                            rdy_q <= 1'b1;
                        end
                    end
                end

                S_INST: begin
                    if (inst_idx < inst_cnt_q) begin
                        inst_v_q <= 1'b1;
                        inst_q   <= store[inst_idx[AW-1:0]];
                        inst_idx <= inst_idx + (AW+1)'(1);
                    end else begin
                        state <= S_FEED;
                        rdy_q <= 1'b1;
                    end
                end

                S_FEED: begin
                    if (bus.s_data_v && rdy_q) begin
                        din_v_q  <= 1'b1;
                        din_q    <= bus.s_data;
                        word_cnt <= word_cnt + CW'(1);
                        if (word_cnt == LAST_WORD) begin
                            rdy_q    <= 1'b0;
                            word_cnt <= '0;
                            if (compute_q == 16'd0) begin
                                state  <= S_LOAD;
                                load_q <= 1'b1;
                            end else begin
                                state <= S_WAIT;
                            end
                        end
                    end
                end

                S_WAIT: begin
                    if (wait_cnt == compute_q - 16'd1) begin
                        state    <= S_LOAD;
                        load_q   <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end

                S_LOAD: begin
                    state    <= S_DRAIN;
                    idle_cnt <= '0;
                end

                S_DRAIN: begin
                    if (bus.dout_overlay_v) begin
                        m_v_q    <= 1'b1;
                        m_q      <= bus.dout_overlay;
                        idle_cnt <= '0;
                        word_cnt <= word_cnt + CW'(1);
                        if (word_cnt == LAST_WORD) begin
                            m_last_q <= 1'b1;
                            state    <= S_DONE;
                        end
                    end else begin
                        if (idle_cnt != IDLE_MAX) begin
                            idle_cnt <= idle_cnt + TW'(1);
                        end
                        // the edge that brings the counter to the limit ends the drain
                        if (idle_cnt >= IDLE_MAX - TW'(1)) begin
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // first DONE cycle raises done; the next returns to IDLE,
                    // so busy stays high alongside done and falls one cycle later
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    rdy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_data_rdy    = rdy_q;
    assign bus.inst_in_v     = inst_v_q;
    assign bus.inst_in       = inst_q;
    assign bus.din_overlay_v = din_v_q;
    assign bus.din_overlay   = din_q;
    assign bus.load          = load_q;
    assign bus.m_data_v      = m_v_q;
    assign bus.m_data        = m_q;
    assign bus.m_data_last   = m_last_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
endmodule
